// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Shares one byte-wide single-port RAM between the CPU instruction-fetch
//   port (IF) and the load/store port (MEM). Every 32-bit access becomes four
//   byte cycles (lane 0 first, little-endian). MEM always wins over IF.
//
// Ports
//   clk, rst                 single clock, synchronous active-high reset
//   if_req_i / if_addr_i     IF word read request (addr[1:0] ignored)
//   if_data_o / if_done_o    fetched word, one-cycle completion pulse
//   mem_req_i, mem_we_i      MEM request, 1 = write
//   mem_addr_i, mem_sel_i    MEM word address, byte enables
//   mem_wdata_i              MEM write data
//   mem_rdata_o / mem_done_o MEM read word (unselected lanes 0), done pulse
//   grant_o                  owner: 00 none, 01 IF, 10 MEM
//   ram_addr_o, ram_we_o,    byte RAM address, write strobe, write byte
//   ram_wdata_o, ram_rdata_i and read byte (RD_LAT cycles after the address)
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W = 17,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [31:0]       if_addr_i,
    output logic [31:0]       if_data_o,
    output logic              if_done_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [31:0]       mem_addr_i,
    input  logic [3:0]        mem_sel_i,
    input  logic [31:0]       mem_wdata_i,
    output logic [31:0]       mem_rdata_o,
    output logic              mem_done_o,
    output logic [1:0]        grant_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic              ram_we_o,
    output logic [7:0]        ram_wdata_o,
    input  logic [7:0]        ram_rdata_i
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t              r_state, w_next;
    logic [1:0]          r_k;
    logic [1:0]          r_dcnt;
    logic                r_is_mem;
    logic [ADDR_W-3:0]   r_addr;
    logic                r_we;
    logic [3:0]          r_sel;
    logic [31:0]         r_wdata;
    logic [31:0]         r_hold;

    // Read-capture pipeline: one entry per issued read byte, aged RD_LAT cycles
    logic [RD_LAT-1:0]       r_cap_vld;
    logic [RD_LAT-1:0][1:0]  r_cap_k;

    logic [31:0]         r_if_data, r_mem_rdata;
    logic                r_if_done, r_mem_done;
    logic [1:0]          r_grant;
    logic [ADDR_W-1:0]   r_ram_addr;
    logic                r_ram_we;
    logic [7:0]          r_ram_wdata;

    // Values latched on a grant, selected by priority
    logic                w_g_any, w_g_mem;
    logic [ADDR_W-3:0]   w_lat_addr;
    logic                w_lat_we;
    logic [3:0]          w_lat_sel;
    logic [31:0]         w_lat_wdata;

    logic [1:0]          w_k1;
    logic                w_cap;
    logic [1:0]          w_cap_k;
    logic [31:0]         w_hold_nxt;
    logic                w_unused;

    assign w_unused = ^{if_addr_i, mem_addr_i};

    assign w_g_any     = mem_req_i | if_req_i;
    assign w_g_mem     = mem_req_i;
    assign w_lat_addr  = w_g_mem ? mem_addr_i[ADDR_W-1:2] : if_addr_i[ADDR_W-1:2];
    assign w_lat_we    = w_g_mem & mem_we_i;
    assign w_lat_sel   = w_g_mem ? mem_sel_i : 4'hF;
    assign w_lat_wdata = w_g_mem ? mem_wdata_i : 32'h0;

    assign w_k1    = r_k + 2'd1;
    assign w_cap   = r_cap_vld[RD_LAT-1];
    assign w_cap_k = r_cap_k[RD_LAT-1];

    // Holding register with the byte returning this cycle merged in, so the
    // last lane can be presented on the data output in the same edge.
    always_comb begin
        w_hold_nxt = r_hold;
        if (w_cap)
            w_hold_nxt[w_cap_k*8 +: 8] = r_sel[w_cap_k] ? ram_rdata_i : 8'h00;
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_g_any) w_next = S_ISSUE;
            S_ISSUE: if (r_k == 2'd3) w_next = r_we ? S_DONE : S_DRAIN;
            S_DRAIN: if (r_dcnt == 2'(RD_LAT-1)) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_k         <= '0;
            r_dcnt      <= '0;
            r_is_mem    <= 1'b0;
            r_addr      <= '0;
            r_we        <= 1'b0;
            r_sel       <= '0;
            r_wdata     <= '0;
            r_hold      <= '0;
            r_cap_vld   <= '0;
            r_cap_k     <= '0;
            r_if_data   <= '0;
            r_mem_rdata <= '0;
            r_if_done   <= 1'b0;
            r_mem_done  <= 1'b0;
            r_grant     <= 2'b00;
            r_ram_addr  <= '0;
            r_ram_we    <= 1'b0;
            r_ram_wdata <= '0;
        end else begin
            r_cap_vld[0] <= (r_state == S_ISSUE) && !r_we;
            r_cap_k[0]   <= r_k;
            for (int i = RD_LAT-1; i > 0; i--) begin
                r_cap_vld[i] <= r_cap_vld[i-1];
                r_cap_k[i]   <= r_cap_k[i-1];
            end
            r_hold   <= w_hold_nxt;
            r_ram_we <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_g_any) begin
                        r_is_mem    <= w_g_mem;
                        r_addr      <= w_lat_addr;
                        r_we        <= w_lat_we;
                        r_sel       <= w_lat_sel;
                        r_wdata     <= w_lat_wdata;
                        r_hold      <= '0;
                        r_k         <= 2'd0;
                        r_dcnt      <= 2'd0;
                        r_grant     <= w_g_mem ? 2'b10 : 2'b01;
                        // lane 0 goes out together with the grant
                        r_ram_addr  <= {w_lat_addr, 2'd0};
                        r_ram_we    <= w_lat_we & w_lat_sel[0];
                        r_ram_wdata <= w_lat_wdata[7:0];
                    end
                end
                S_ISSUE: begin
                    r_k <= w_k1;
                    if (r_k != 2'd3) begin
                        r_ram_addr  <= {r_addr, w_k1};
                        r_ram_we    <= r_we & r_sel[w_k1];
                        r_ram_wdata <= r_wdata[w_k1*8 +: 8];
                    end
                end
                S_DRAIN: r_dcnt <= r_dcnt + 2'd1;
                S_DONE: begin
                    r_if_done  <= 1'b0;
                    r_mem_done <= 1'b0;
                    r_grant    <= 2'b00;
                end
                default: ;
            endcase

            // Done and read data are presented in the DONE cycle. Writes
            // return no data, so the read word outputs keep their value.
            if (r_state != S_DONE && w_next == S_DONE) begin
                if (r_is_mem) r_mem_done <= 1'b1;
                else          r_if_done  <= 1'b1;
                if (!r_we) begin
                    if (r_is_mem) r_mem_rdata <= w_hold_nxt;
                    else          r_if_data   <= w_hold_nxt;
                end
            end
        end
    end

    assign if_data_o   = r_if_data;
    assign if_done_o   = r_if_done;
    assign mem_rdata_o = r_mem_rdata;
    assign mem_done_o  = r_mem_done;
    assign grant_o     = r_grant;
    assign ram_addr_o  = r_ram_addr;
    assign ram_we_o    = r_ram_we;
    assign ram_wdata_o = r_ram_wdata;

endmodule
